// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: shared constants for the input conditioner
package input_conditioner_pkg;
  localparam int N_CH = 4;
  localparam int GLITCH_CNT_W = 8;
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_SAT = 8'hFF;
endpackage

// File: rtl/input_conditioner_if.sv
// input_conditioner_if: raw inputs, conditioned levels/pulses and glitch diagnostics
interface input_conditioner_if
  import input_conditioner_pkg::*;
#(
  parameter int N = N_CH
);
  logic [N-1:0] raw_i;
  logic [N-1:0] clean_o;
  logic [N-1:0] rise_o;
  logic [N-1:0] fall_o;
  logic glitch_clr;
  logic [GLITCH_CNT_W-1:0] glitch_cnt_o;
  modport master (output raw_i, glitch_clr, input clean_o, rise_o, fall_o, glitch_cnt_o);
  modport slave (input raw_i, glitch_clr, output clean_o, rise_o, fall_o, glitch_cnt_o);
endinterface

// File: rtl/debounce_ch.sv
// debounce_ch: one channel of 2-flop sync, debounce counter, clean level and edge pulses
module debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic glitch_evt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic sync1, sync2, diff, accept;
  logic [CW-1:0] cnt;
  assign diff = sync2 != clean;
  assign accept = diff && cnt == LAST;
  // a partial count abandoned because the level fell back is a rejected glitch
  assign glitch_evt = !diff && |cnt;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      sync1 <= RST_VAL;
      sync2 <= RST_VAL;
      clean <= RST_VAL;
      cnt <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      cnt <= (diff && !accept) ? cnt + 1'b1 : '0;
      clean <= accept ? sync2 : clean;
      rise <= accept && sync2;
      fall <= accept && !sync2;
    end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: per-channel sync/debounce with a shared saturating glitch counter
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int N_CH = input_conditioner_pkg::N_CH,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter logic [N_CH-1:0] RST_VAL = '0
) (
  input logic clk,
  input logic n_rst,
  input_conditioner_if.slave bus
);
  logic [N_CH-1:0] clean, rise, fall, evt;
  logic [GLITCH_CNT_W-1:0] glitch_cnt;
  logic [GLITCH_CNT_W:0] sum;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RST_VAL(RST_VAL[i])
    ) u_ch (
      .clk(clk),
      .n_rst(n_rst),
      .raw(bus.raw_i[i]),
      .clean(clean[i]),
      .rise(rise[i]),
      .fall(fall[i]),
      .glitch_evt(evt[i])
    );
  end
  // one spare bit so overflow is visible before clamping
  assign sum = {1'b0, glitch_cnt} + (GLITCH_CNT_W + 1)'($countones(evt));
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) glitch_cnt <= '0;
    else glitch_cnt <= bus.glitch_clr ? '0 : (sum > {1'b0, GLITCH_SAT}) ? GLITCH_SAT : sum[GLITCH_CNT_W-1:0];
  assign bus.clean_o = clean;
  assign bus.rise_o = rise;
  assign bus.fall_o = fall;
  assign bus.glitch_cnt_o = glitch_cnt;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed and random stimulus checked against a
// sliding-window reference model of the debounce rules
module tb_input_conditioner;
  localparam int DC = 8;
  localparam int N = 4;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  input_conditioner_if #(.N(N)) bus ();
  input_conditioner #(
    .N_CH(N),
    .DEBOUNCE_CYCLES(DC),
    .RST_VAL(4'b0000)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  int rise_tot = 0;
  logic [N-1:0] m_s1, m_s2, m_clean, m_rise, m_fall;
  logic [DC-1:0] m_hist [N];
  int m_gc;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_s1 = '0;
    m_s2 = '0;
    m_clean = '0;
    m_rise = '0;
    m_fall = '0;
    m_gc = 0;
    for (int i = 0; i < N; i++) m_hist[i] = '0;
  endtask
  // a level is accepted once the last DC synchronised samples all disagree with clean;
  // a glitch is a sample back at clean right after a disagreeing one
  task automatic model_edge(input logic [N-1:0] raw, input logic clr);
    int n;
    logic cur, acc;
    logic [DC-1:0] win;
    n = 0;
    for (int i = 0; i < N; i++) begin
      cur = m_s2[i];
      win = {m_hist[i][DC-2:0], cur};
      if (cur == m_clean[i] && m_hist[i][0] != m_clean[i]) n++;
      acc = (win == {DC{~m_clean[i]}});
      m_rise[i] = acc && cur;
      m_fall[i] = acc && !cur;
      if (acc) m_clean[i] = cur;
      m_hist[i] = win;
    end
    m_s2 = m_s1;
    m_s1 = raw;
    m_gc = clr ? 0 : (m_gc + n > 255 ? 255 : m_gc + n);
  endtask
  function automatic int pending_evt();
    int n;
    n = 0;
    for (int i = 0; i < N; i++)
      if (m_s2[i] == m_clean[i] && m_hist[i][0] != m_clean[i]) n++;
    return n;
  endfunction
  task automatic compare_all(input string tag);
    check({tag, ".clean"}, 32'(bus.clean_o), 32'(m_clean));
    check({tag, ".rise"}, 32'(bus.rise_o), 32'(m_rise));
    check({tag, ".fall"}, 32'(bus.fall_o), 32'(m_fall));
    check({tag, ".glitch"}, 32'(bus.glitch_cnt_o), 32'(m_gc));
  endtask
  task automatic step(input logic [N-1:0] raw, input logic clr);
    bus.raw_i = raw;
    bus.glitch_clr = clr;
    @(posedge clk);
    model_edge(raw, clr);
    #1;
    rise_tot += $countones(bus.rise_o);
    compare_all("step");
  endtask
  task automatic do_reset(input logic [N-1:0] raw);
    bus.raw_i = raw;
    bus.glitch_clr = 1'b0;
    n_rst = 1'b0;
    #1;
    model_reset();
    compare_all("rst");
    @(posedge clk);
    #1;
    compare_all("rst_hold");
    n_rst = 1'b1;
  endtask
  task automatic wait_pulse(input logic [N-1:0] raw, input int ch, input bit is_fall, output int n);
    n = 99;
    for (int s = 1; s <= 40; s++) begin
      step(raw, 1'b0);
      if (is_fall ? bus.fall_o[ch] : bus.rise_o[ch]) begin
        n = s;
        break;
      end
    end
  endtask
  task automatic burst(input logic [N-1:0] mask);
    repeat (2) step(mask, 1'b0);
    repeat (4) step('0, 1'b0);
  endtask
  initial begin
    int n, r0, rs, fs;
    bit found;
    int hold [N];
    logic [N-1:0] cur;
    bus.raw_i = '0;
    bus.glitch_clr = 1'b0;
    do_reset(4'hF);
    wait_pulse(4'hF, 0, 1'b0, n);
    check("rst_latency", 32'(n), 32'(DC + 2));
    check("rst_rise_all", 32'(bus.rise_o), 32'hF);
    check("rst_clean_all", 32'(bus.clean_o), 32'hF);
    step(4'hF, 1'b0);
    check("rise_one_cycle", 32'(bus.rise_o), 32'h0);
    do_reset('0);
    r0 = rise_tot;
    repeat (3) begin
      repeat (3) step(4'h1, 1'b0);
      repeat (3) step(4'h0, 1'b0);
    end
    wait_pulse(4'h1, 0, 1'b0, n);
    check("bounce_latency", 32'(n), 32'(DC + 2));
    check("bounce_glitches", 32'(bus.glitch_cnt_o), 32'd3);
    repeat (5) step(4'h1, 1'b0);
    check("bounce_single_rise", 32'(rise_tot - r0), 32'd1);
    do_reset('0);
    r0 = rise_tot;
    repeat (DC - 1) step(4'h2, 1'b0);
    repeat (6) step(4'h0, 1'b0);
    check("w_short_glitch", 32'(bus.glitch_cnt_o), 32'd1);
    check("w_short_norise", 32'(rise_tot - r0), 32'd0);
    rs = 0;
    fs = 0;
    for (int s = 1; s <= 30; s++) begin
      step((s <= DC) ? 4'h2 : 4'h0, 1'b0);
      if (bus.rise_o[1]) rs = s;
      if (bus.fall_o[1]) fs = s;
    end
    check("w_min_rise", 32'(rs), 32'(DC + 2));
    check("w_min_fall", 32'(fs), 32'(2 * DC + 2));
    check("w_min_glitch", 32'(bus.glitch_cnt_o), 32'd1);
    do_reset('0);
    burst(4'hF);
    check("sim4", 32'(bus.glitch_cnt_o), 32'd4);
    repeat (62) burst(4'hF);
    burst(4'h1);
    check("pre253", 32'(bus.glitch_cnt_o), 32'd253);
    burst(4'hF);
    check("sat255", 32'(bus.glitch_cnt_o), 32'd255);
    burst(4'hF);
    check("sat_hold", 32'(bus.glitch_cnt_o), 32'd255);
    repeat (3) step(4'h3, 1'b0);
    found = 1'b0;
    for (int s = 0; s < 10 && !found; s++) begin
      if (pending_evt() == 2) begin
        step('0, 1'b1);
        found = 1'b1;
      end else step('0, 1'b0);
    end
    check("clr_found", 32'(found), 32'd1);
    check("clr_priority", 32'(bus.glitch_cnt_o), 32'd0);
    do_reset('0);
    repeat (7) step(4'h4, 1'b0);
    do_reset(4'h4);
    check("mid_rst_clean", 32'(bus.clean_o), 32'h0);
    check("mid_rst_rise", 32'(bus.rise_o), 32'h0);
    wait_pulse(4'h4, 2, 1'b0, n);
    check("mid_rst_restart", 32'(n), 32'(DC + 2));
    check("mid_rst_noglitch", 32'(bus.glitch_cnt_o), 32'd0);
    do_reset('0);
    cur = '0;
    for (int c = 0; c < N; c++) hold[c] = 0;
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          cur[c] = 1'($urandom_range(0, 1));
          hold[c] = int'($urandom_range(1, 14));
        end
        hold[c]--;
      end
      if ($urandom_range(0, 999) == 0) do_reset(cur);
      step(cur, $urandom_range(0, 63) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
